seq_alu: RTL and testbench

- Parametrised, registered successor to the combinational datapath ALU.
- Single-cycle logic, arithmetic, shift and rotate ops; iterative signed Booth multiply and signed non-restoring divide.
- start/busy/done handshake; 2*WIDTH-bit HI:LO result plus status flags.
- Sits between the A/B operand registers and the Z (HI/LO) register of the CPU datapath; the control unit waits on done.

---
 rtl/seq_alu.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with single-cycle logic/arith/shift/rotate ops and
// iterative signed Booth multiply and signed non-restoring divide.
//
// Ports:
//   clock    - system clock, rising edge
//   clear    - synchronous active-high reset
//   start    - operation request, sampled only while idle
//   op       - operation code, latched with start
//   A, B     - operands (WIDTH bits), latched with start
//   result   - {HI,LO} registered result, held until the next done
//   done     - one-cycle pulse, result and flags valid
//   busy     - high while MUL or DIV iterates
//   carry    - ADD/SUB carry-out (SUB: 1 = no borrow)
//   overflow - signed overflow for ADD/SUB/NEG, MIN/-1 for DIV
//   zero     - full 2*WIDTH result is zero
//   div_zero - DIV with B == 0
//
// Build option: define MUL_RADIX4_EN to use radix-4 modified Booth for MUL
// (2 multiplier bits per cycle, WIDTH/2 cycles); default is radix-2.

module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done,
    output logic                 busy,
    output logic                 carry,
    output logic                 overflow,
    output logic                 zero,
    output logic                 div_zero
);

    localparam int SHW = $clog2(WIDTH);
    // Shared HI register: Booth accumulator or signed partial remainder.
    localparam int RW  = WIDTH + 2;
`ifdef MUL_RADIX4_EN
    localparam int MUL_STEPS = WIDTH / 2;
`else
    localparam int MUL_STEPS = WIDTH;
`endif

    typedef enum logic [1:0] {IDLE, MUL_ITER, DIV_ITER, DIV_FIX} state_t;

    typedef enum logic [3:0] {
        OP_OR   = 4'd0,  OP_AND  = 4'd1,  OP_NOT = 4'd2,  OP_ADD = 4'd3,
        OP_SUB  = 4'd4,  OP_NEG  = 4'd5,  OP_MUL = 4'd6,  OP_DIV = 4'd7,
        OP_SHL  = 4'd8,  OP_SHR  = 4'd9,  OP_SHRA = 4'd10, OP_ROL = 4'd11,
        OP_ROR  = 4'd12
    } op_t;

    state_t             r_state, w_state_n;
    logic [SHW-1:0]     r_cnt, w_cnt_n;
    logic [RW-1:0]      r_hi, w_hi_n;
    logic [WIDTH-1:0]   r_lo, w_lo_n;
    logic               r_q1, w_q1_n;
    logic [WIDTH-1:0]   r_opa, w_opa_n;
    logic               r_neg_q, w_neg_q_n;
    logic               r_neg_r, w_neg_r_n;
    logic               r_div_ovf, w_div_ovf_n;
    logic [2*WIDTH-1:0] r_result, w_result_n;
    logic               r_done, w_done_n;
    logic               r_carry, w_carry_n;
    logic               r_overflow, w_overflow_n;
    logic               r_zero, w_zero_n;
    logic               r_div_zero, w_div_zero_n;

    // ---------------- single-cycle datapath ----------------
    logic [SHW-1:0]   w_amt;
    logic [SHW:0]     w_inv_amt;
    logic [WIDTH:0]   w_add, w_sub;
    logic [WIDTH-1:0] w_neg;
    logic [WIDTH-1:0] w_alu;
    logic             w_alu_c, w_alu_v;

    assign w_amt     = B[SHW-1:0];
    // Complementary rotate amount; amt=0 gives WIDTH, which shifts fully out.
    assign w_inv_amt = (SHW+1)'(WIDTH) - {1'b0, w_amt};
    assign w_add     = {1'b0, A} + {1'b0, B};
    assign w_sub     = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    assign w_neg     = '0 - A;

    always_comb begin
        w_alu   = '0;
        w_alu_c = 1'b0;
        w_alu_v = 1'b0;
        case (op)
            OP_OR:   w_alu = A | B;
            OP_AND:  w_alu = A & B;
            OP_NOT:  w_alu = ~A;
            OP_ADD: begin
                w_alu   = w_add[WIDTH-1:0];
                w_alu_c = w_add[WIDTH];
                w_alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu   = w_sub[WIDTH-1:0];
                w_alu_c = w_sub[WIDTH];
                w_alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
            end
            OP_NEG: begin
                w_alu   = w_neg;
                // Only the most-negative value negates to a negative result.
                w_alu_v = A[WIDTH-1] & w_neg[WIDTH-1];
            end
            OP_SHL:  w_alu = A << w_amt;
            OP_SHR:  w_alu = A >> w_amt;
            OP_SHRA: w_alu = $signed(A) >>> w_amt;
            OP_ROL:  w_alu = (A << w_amt) | (A >> w_inv_amt);
            OP_ROR:  w_alu = (A >> w_amt) | (A << w_inv_amt);
            default: w_alu = '0;
        endcase
    end

    // ---------------- Booth multiply step ----------------
    // {r_hi, r_lo, r_q1} is the Booth product register; r_opa the multiplicand.
    logic [RW-1:0]    w_mx, w_msum, w_mhi_n;
    logic [WIDTH-1:0] w_mlo_n;
    logic             w_mq1_n;

    always_comb begin
        w_mx = {{2{r_opa[WIDTH-1]}}, r_opa};
`ifdef MUL_RADIX4_EN
        case ({r_lo[1:0], r_q1})
            3'b001, 3'b010: w_msum = r_hi + w_mx;
            3'b011:         w_msum = r_hi + (w_mx << 1);
            3'b100:         w_msum = r_hi - (w_mx << 1);
            3'b101, 3'b110: w_msum = r_hi - w_mx;
            default:        w_msum = r_hi;
        endcase
        w_mhi_n = {{2{w_msum[RW-1]}}, w_msum[RW-1:2]};
        w_mlo_n = {w_msum[1:0], r_lo[WIDTH-1:2]};
        w_mq1_n = r_lo[1];
`else
        case ({r_lo[0], r_q1})
            2'b01:   w_msum = r_hi + w_mx;
            2'b10:   w_msum = r_hi - w_mx;
            default: w_msum = r_hi;
        endcase
        w_mhi_n = {w_msum[RW-1], w_msum[RW-1:1]};
        w_mlo_n = {w_msum[0], r_lo[WIDTH-1:1]};
        w_mq1_n = r_lo[0];
`endif
    end

    // ---------------- non-restoring divide step ----------------
    // Operates on magnitudes: r_hi = signed partial remainder, r_lo = dividend
    // shifting out / quotient shifting in, r_opa = |divisor|.
    logic [RW-1:0]    w_rsh, w_dx, w_rnew;
    logic [WIDTH-1:0] w_qnew, w_rmag, w_rem, w_quo;

    assign w_dx   = {2'b00, r_opa};
    assign w_rsh  = {r_hi[RW-2:0], r_lo[WIDTH-1]};
    assign w_rnew = r_hi[RW-1] ? (w_rsh + w_dx) : (w_rsh - w_dx);
    assign w_qnew = {r_lo[WIDTH-2:0], ~w_rnew[RW-1]};
    // Final magnitude lies in [0, |B|), so WIDTH-bit arithmetic is exact.
    assign w_rmag = r_hi[RW-1] ? (r_hi[WIDTH-1:0] + r_opa) : r_hi[WIDTH-1:0];
    assign w_rem  = r_neg_r ? ('0 - w_rmag) : w_rmag;
    assign w_quo  = r_neg_q ? ('0 - r_lo) : r_lo;

    // ---------------- next-state / next-output logic ----------------
    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_hi_n       = r_hi;
        w_lo_n       = r_lo;
        w_q1_n       = r_q1;
        w_opa_n      = r_opa;
        w_neg_q_n    = r_neg_q;
        w_neg_r_n    = r_neg_r;
        w_div_ovf_n  = r_div_ovf;
        w_result_n   = r_result;
        w_done_n     = 1'b0;
        w_carry_n    = r_carry;
        w_overflow_n = r_overflow;
        w_zero_n     = r_zero;
        w_div_zero_n = r_div_zero;

        case (r_state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        w_state_n = MUL_ITER;
                        w_cnt_n   = '0;
                        w_hi_n    = '0;
                        w_lo_n    = B;
                        w_q1_n    = 1'b0;
                        w_opa_n   = A;
                    end else if (op == OP_DIV && B != '0) begin
                        w_state_n   = DIV_ITER;
                        w_cnt_n     = '0;
                        w_hi_n      = '0;
                        w_lo_n      = A[WIDTH-1] ? ('0 - A) : A;
                        w_opa_n     = B[WIDTH-1] ? ('0 - B) : B;
                        w_neg_q_n   = A[WIDTH-1] ^ B[WIDTH-1];
                        w_neg_r_n   = A[WIDTH-1];
                        w_div_ovf_n = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
                    end else if (op == OP_DIV) begin
                        w_done_n     = 1'b1;
                        w_result_n   = '0;
                        w_carry_n    = 1'b0;
                        w_overflow_n = 1'b0;
                        w_div_zero_n = 1'b1;
                    end else begin
                        w_done_n     = 1'b1;
                        w_result_n   = {{WIDTH{1'b0}}, w_alu};
                        w_carry_n    = w_alu_c;
                        w_overflow_n = w_alu_v;
                        w_div_zero_n = 1'b0;
                    end
                end
            end
            MUL_ITER: begin
                w_hi_n  = w_mhi_n;
                w_lo_n  = w_mlo_n;
                w_q1_n  = w_mq1_n;
                w_cnt_n = r_cnt + SHW'(1);
                if (r_cnt == SHW'(MUL_STEPS - 1)) begin
                    w_state_n    = IDLE;
                    w_done_n     = 1'b1;
                    w_result_n   = {w_mhi_n[WIDTH-1:0], w_mlo_n};
                    w_carry_n    = 1'b0;
                    w_overflow_n = 1'b0;
                    w_div_zero_n = 1'b0;
                end
            end
            DIV_ITER: begin
                w_hi_n  = w_rnew;
                w_lo_n  = w_qnew;
                w_cnt_n = r_cnt + SHW'(1);
                if (r_cnt == SHW'(WIDTH - 1)) begin
                    w_state_n = DIV_FIX;
                end
            end
            DIV_FIX: begin
                w_state_n    = IDLE;
                w_done_n     = 1'b1;
                w_result_n   = {w_rem, w_quo};
                w_carry_n    = 1'b0;
                w_overflow_n = r_div_ovf;
                w_div_zero_n = 1'b0;
            end
            default: w_state_n = IDLE;
        endcase

        if (w_done_n) begin
            w_zero_n = (w_result_n == '0);
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // ---------------- datapath / output registers ----------------
    always_ff @(posedge clock) begin
        if (clear) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_q1       <= 1'b0;
            r_opa      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_ovf  <= 1'b0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_n;
            r_hi       <= w_hi_n;
            r_lo       <= w_lo_n;
            r_q1       <= w_q1_n;
            r_opa      <= w_opa_n;
            r_neg_q    <= w_neg_q_n;
            r_neg_r    <= w_neg_r_n;
            r_div_ovf  <= w_div_ovf_n;
            r_result   <= w_result_n;
            r_done     <= w_done_n;
            r_carry    <= w_carry_n;
            r_overflow <= w_overflow_n;
            r_zero     <= w_zero_n;
            r_div_zero <= w_div_zero_n;
        end
    end

    assign result   = r_result;
    assign done     = r_done;
    assign busy     = (r_state != IDLE);
    assign carry    = r_carry;
    assign overflow = r_overflow;
    assign zero     = r_zero;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: self-checking bench for seq_alu (WIDTH=32) using directed
// cases plus randomized operations against an arithmetic reference model.

module tb_seq_alu;

    logic        clock;
    logic        clear;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic [63:0] result;
    logic        done;
    logic        busy;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

`ifdef MUL_RADIX4_EN
    localparam int MUL_LAT = 16;
`else
    localparam int MUL_LAT = 32;
`endif

    seq_alu #(.WIDTH(32)) dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .div_zero (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic. flags = {carry,overflow,zero,div_zero};
    // lat = extra clock edges between the start edge and the done edge.
    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] res, output logic [3:0] flags, output int lat);
        longint sa, sb, s, q, r;
        logic [32:0] us;
        logic [31:0] t;
        logic c, v, dz;
        int amt;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        amt = int'(b[4:0]);
        c = 1'b0; v = 1'b0; dz = 1'b0; lat = 0; res = '0;
        case (o)
            4'd0: res = {32'h0, a | b};
            4'd1: res = {32'h0, a & b};
            4'd2: res = {32'h0, ~a};
            4'd3: begin
                us = {1'b0, a} + {1'b0, b};
                s = sa + sb;
                res = {32'h0, us[31:0]};
                c = us[32];
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4: begin
                s = sa - sb;
                t = a - b;
                res = {32'h0, t};
                c = (a >= b);
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd5: begin
                s = -sa;
                t = -a;
                res = {32'h0, t};
                v = (s > 64'sd2147483647);
            end
            4'd6: begin
                res = 64'(sa * sb);
                lat = MUL_LAT;
            end
            4'd7: begin
                if (b == 32'h0) begin
                    dz = 1'b1;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                    v = (q > 64'sd2147483647);
                    lat = 33;
                end
            end
            4'd8:  res = {32'h0, a << amt};
            4'd9:  res = {32'h0, a >> amt};
            4'd10: begin
                t = 32'($signed(a) >>> amt);
                res = {32'h0, t};
            end
            4'd11: begin
                t = a;
                for (int i = 0; i < amt; i++) t = {t[30:0], t[31]};
                res = {32'h0, t};
            end
            4'd12: begin
                t = a;
                for (int i = 0; i < amt; i++) t = {t[0], t[31:1]};
                res = {32'h0, t};
            end
            default: res = '0;
        endcase
        flags = {c, v, (res == 64'h0), dz};
    endfunction

    // Issue one operation and check latency, busy, result, flags and done pulse.
    // With noise set, start stays high with random op/A/B while busy.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit noise);
        logic [63:0] er;
        logic [3:0]  ef;
        int el;
        int n;
        model(o, a, b, er, ef, el);
        @(negedge clock);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clock); #1;
        chk("busy_at_start", 64'(busy), 64'(el > 0));
        n = 0;
        start = noise && (el > 0);
        while (!done && n < 200) begin
            if (start) begin
                op = 4'($urandom_range(0, 15)); A = $urandom; B = $urandom;
            end
            @(posedge clock); #1;
            n++;
        end
        start = 1'b0;
        chk("latency", 64'(n), 64'(el));
        chk("done", 64'(done), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        chk("result", result, er);
        chk("flags", 64'({carry, overflow, zero, div_zero}), 64'(ef));
        @(posedge clock); #1;
        chk("done_pulse", 64'(done), 64'd0);
        chk("result_held", result, er);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [63:0] er;
        logic [3:0]  ef;
        int el;
        int seen;
        logic [3:0] o;
        logic [31:0] a, b;

        clear = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_result", result, 64'h0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_flags", 64'({carry, overflow, zero, div_zero}), 64'd0);
        clear = 1'b0;

        // Directed cases
        run_op(4'd3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        chk("add_ovf_value", result, 64'h0000_0000_8000_0000);
        run_op(4'd6, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
        chk("mul_value", result, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(4'd7, 32'hFFFF_FFEF, 32'h0000_0005, 1'b1);
        chk("div_value", result, 64'hFFFF_FFFE_FFFF_FFFD);
        run_op(4'd7, 32'h0000_0005, 32'h0000_0000, 1'b0);
        chk("divz_flags", 64'({zero, div_zero}), 64'd3);
        run_op(4'd11, 32'h1234_5678, 32'h0000_0004, 1'b0);
        chk("rol_value", result, 64'h0000_0000_2345_6781);
        run_op(4'd12, 32'h1234_5678, 32'h0000_0020, 1'b0);
        chk("ror0_value", result, 64'h0000_0000_1234_5678);
        run_op(4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_minneg", result, 64'h0000_0000_8000_0000);
        run_op(4'd6, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(4'd6, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        run_op(4'd4, 32'h0000_0003, 32'h0000_0005, 1'b0);
        run_op(4'd5, 32'h8000_0000, 32'h0, 1'b0);
        run_op(4'd10, 32'h8000_0F00, 32'h0000_0024, 1'b0);
        run_op(4'd14, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        run_op(4'd7, 32'h0000_0007, 32'hFFFF_FFF6, 1'b0);

        // Back-to-back single-cycle ops with start held high
        for (int i = 0; i < 10; i++) begin
            o = 4'($urandom_range(0, 5));
            if (o == 4'd6 || o == 4'd7) o = 4'd3;
            if (i % 2 == 1) o = 4'($urandom_range(8, 15));
            a = rnd_val(); b = rnd_val();
            model(o, a, b, er, ef, el);
            @(negedge clock);
            start = 1'b1; op = o; A = a; B = b;
            @(posedge clock); #1;
            chk("b2b_done", 64'(done), 64'd1);
            chk("b2b_result", result, er);
            chk("b2b_flags", 64'({carry, overflow, zero, div_zero}), 64'(ef));
        end
        @(negedge clock);
        start = 1'b0;
        @(posedge clock); #1;

        // Clear in the middle of a divide
        @(negedge clock);
        start = 1'b1; op = 4'd7; A = 32'd100; B = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        chk("clr_busy_before", 64'(busy), 64'd1);
        repeat (10) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_done", 64'(done), 64'd0);
        chk("clr_result", result, 64'h0);
        chk("clr_flags", 64'({carry, overflow, zero, div_zero}), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done || busy) seen++;
        end
        chk("clr_no_done", 64'(seen), 64'd0);
        run_op(4'd3, 32'd2, 32'd3, 1'b0);
        chk("clr_add_value", result, 64'd5);

        // Randomized operations
        for (int i = 0; i < 70; i++) begin
            o = 4'($urandom_range(0, 15));
            a = rnd_val();
            b = rnd_val();
            if (o >= 4'd8 && o <= 4'd12 && $urandom_range(0, 1) == 1) b = $urandom_range(0, 40);
            run_op(o, a, b, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
